// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_port_arbiter
// Purpose  : Shares the single-ported data memory between the M-stage CPU
//            port and one external burst requester (DMA / debug bridge).
//            CPU has priority; a starvation counter forces external progress.
//            External accesses run as bounded, address-incrementing bursts.
// Options  : `define DM_ARB_RANGE_CHECK_EN adds a registered o_range_err port
//            and suppresses out-of-range / misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
module dm_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic              clk,
  input  logic              rst,
  // CPU port
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [31:0]       i_cpu_addr,
  input  logic [31:0]       i_cpu_wdata,
  input  logic [3:0]        i_cpu_be,
  output logic              o_cpu_stall,
  output logic              o_cpu_rvalid,
  output logic [31:0]       o_cpu_rdata,
  // External port
  input  logic              i_ext_req,
  input  logic              i_ext_we,
  input  logic [31:0]       i_ext_addr,
  input  logic [3:0]        i_ext_len,
  input  logic [31:0]       i_ext_wdata,
  output logic              o_ext_gnt,
  output logic              o_ext_rvalid,
  output logic [31:0]       o_ext_rdata,
  output logic              o_ext_done,
  // Memory port
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
`ifdef DM_ARB_RANGE_CHECK_EN
  ,
  output logic              o_range_err
`endif
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] C_STARVE_MAX = SC_W'(STARVE_MAX);
  localparam logic [3:0]      C_BURST_MAX  = 4'(BURST_MAX);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    EXT_BURST = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SC_W-1:0]   r_starve_cnt;
  logic [ADDR_W-1:0] r_base;
  logic [3:0]        r_beats;
  logic [3:0]        r_beat_idx;
  logic              r_dir;
  logic              r_ext_bad;
  logic              r_cpu_rvalid;
  logic              r_ext_rvalid;
  logic              r_cpu_rd_bad;
  logic              r_ext_rd_bad;

  logic              w_cpu_issue;
  logic              w_ext_issue;
  logic              w_ext_start;
  logic [3:0]        w_len;
  logic [ADDR_W-1:0] w_ext_addr;
  logic              w_ext_dir;
  logic              w_ext_bad_cur;
  logic              w_cpu_bad;
  logic              w_ext_bad_new;

  // Length 0 means one word; anything beyond the burst limit is clamped.
  assign w_len = (i_ext_len == 4'd0)        ? 4'd1 :
                 (i_ext_len > C_BURST_MAX)  ? C_BURST_MAX : i_ext_len;

  // The first beat comes straight from the request; later beats from the latched burst.
  assign w_ext_addr    = (r_state == IDLE) ? i_ext_addr[ADDR_W+1:2]
                                           : r_base + ADDR_W'(r_beat_idx);
  assign w_ext_dir     = (r_state == IDLE) ? i_ext_we : r_dir;
  assign w_ext_bad_cur = (r_state == IDLE) ? w_ext_bad_new : r_ext_bad;

`ifdef DM_ARB_RANGE_CHECK_EN
  // Addresses beyond the memory, or a misaligned full-word CPU access, are rejected.
  assign w_cpu_bad     = (|i_cpu_addr[31:ADDR_W+2]) ||
                         ((|i_cpu_addr[1:0]) && (i_cpu_be == 4'hF));
  assign w_ext_bad_new = |i_ext_addr[31:ADDR_W+2];

  logic w_unused_bits;
  assign w_unused_bits = ^i_ext_addr[1:0];
`else
  assign w_cpu_bad     = 1'b0;
  assign w_ext_bad_new = 1'b0;

  // Upper and byte-offset address bits are intentionally ignored.
  logic w_unused_bits;
  assign w_unused_bits = ^{i_cpu_addr[31:ADDR_W+2], i_cpu_addr[1:0],
                           i_ext_addr[31:ADDR_W+2], i_ext_addr[1:0]};
`endif

  // Arbitration, next-state and memory-port steering.
  always_comb begin
    w_state_nxt = r_state;
    w_cpu_issue = 1'b0;
    w_ext_issue = 1'b0;
    w_ext_start = 1'b0;
    o_cpu_stall = 1'b0;
    o_ext_gnt   = 1'b0;
    o_ext_done  = 1'b0;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_be    = 4'h0;
    o_mem_wdata = 32'h0;

    case (r_state)
      IDLE: begin
        if (i_cpu_req && (r_starve_cnt < C_STARVE_MAX)) begin
          w_cpu_issue = 1'b1;
        end else if (i_ext_req) begin
          w_ext_issue = 1'b1;
          w_ext_start = 1'b1;
          o_ext_gnt   = 1'b1;
          o_cpu_stall = i_cpu_req;
          if (w_len > 4'd1) begin
            w_state_nxt = EXT_BURST;
          end else begin
            o_ext_done  = 1'b1;
          end
        end
      end
      EXT_BURST: begin
        w_ext_issue = 1'b1;
        o_ext_gnt   = 1'b1;
        o_cpu_stall = i_cpu_req;
        if (r_beat_idx == (r_beats - 4'd1)) begin
          o_ext_done  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_cpu_issue) begin
      o_mem_en    = !w_cpu_bad;
      o_mem_we    = i_cpu_we;
      o_mem_addr  = i_cpu_addr[ADDR_W+1:2];
      o_mem_be    = i_cpu_be;
      o_mem_wdata = i_cpu_wdata;
    end else if (w_ext_issue) begin
      o_mem_en    = !w_ext_bad_cur;
      o_mem_we    = w_ext_dir;
      o_mem_addr  = w_ext_addr;
      o_mem_be    = 4'hF;
      o_mem_wdata = i_ext_wdata;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Burst context: latched when a burst wins arbitration, index advances per beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base     <= '0;
      r_beats    <= 4'd0;
      r_beat_idx <= 4'd0;
      r_dir      <= 1'b0;
      r_ext_bad  <= 1'b0;
    end else if (w_ext_start) begin
      r_base     <= i_ext_addr[ADDR_W+1:2];
      r_beats    <= w_len;
      r_beat_idx <= 4'd1;
      r_dir      <= i_ext_we;
      r_ext_bad  <= w_ext_bad_new;
    end else if (r_state == EXT_BURST) begin
      r_beat_idx <= r_beat_idx + 4'd1;
    end
  end

  // Starvation counter: counts denied external cycles, cleared on any grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (o_ext_gnt) begin
      r_starve_cnt <= '0;
    end else if (i_ext_req && (r_starve_cnt < C_STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Read-return tracking, one cycle behind the issuing access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpu_rvalid <= 1'b0;
      r_ext_rvalid <= 1'b0;
      r_cpu_rd_bad <= 1'b0;
      r_ext_rd_bad <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_cpu_issue && !i_cpu_we;
      r_ext_rvalid <= w_ext_issue && !w_ext_dir;
      r_cpu_rd_bad <= w_cpu_issue && w_cpu_bad;
      r_ext_rd_bad <= w_ext_issue && w_ext_bad_cur;
    end
  end

  assign o_cpu_rvalid = r_cpu_rvalid;
  assign o_ext_rvalid = r_ext_rvalid;
  assign o_cpu_rdata  = (r_cpu_rvalid && !r_cpu_rd_bad) ? i_mem_rdata : 32'h0;
  assign o_ext_rdata  = (r_ext_rvalid && !r_ext_rd_bad) ? i_mem_rdata : 32'h0;

`ifdef DM_ARB_RANGE_CHECK_EN
  logic r_range_err;

  // One-cycle error pulse for any issued access that failed the range check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_range_err <= 1'b0;
    else     r_range_err <= (w_cpu_issue && w_cpu_bad) || (w_ext_issue && w_ext_bad_cur);
  end

  assign o_range_err = r_range_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_port_arbiter
// Purpose  : Self-checking bench for dm_port_arbiter: single-cycle vector
//            table plus directed burst, starvation, wrap and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic [3:0]  ext_len;
  logic        ext_gnt, ext_rvalid, ext_done;
  logic [31:0] ext_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
`ifdef DM_ARB_RANGE_CHECK_EN
  logic        range_err;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.ADDR_W(12), .STARVE_MAX(4), .BURST_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .i_cpu_be(cpu_be),
    .o_cpu_stall(cpu_stall), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
    .i_ext_req(ext_req), .i_ext_we(ext_we), .i_ext_addr(ext_addr),
    .i_ext_len(ext_len), .i_ext_wdata(ext_wdata),
    .o_ext_gnt(ext_gnt), .o_ext_rvalid(ext_rvalid), .o_ext_rdata(ext_rdata),
    .o_ext_done(ext_done),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_be(mem_be), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
`ifdef DM_ARB_RANGE_CHECK_EN
    , .o_range_err(range_err)
`endif
  );

  // Behavioural single-port memory, read data one cycle after the strobe.
  logic [31:0] mem [0:4095];
  initial for (int i = 0; i < 4096; i++) mem[i] = 32'hD000_0000 + 32'(i);
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected memory contents after the writes performed earlier in the run.
  function automatic logic [31:0] exp_word(input logic [11:0] a);
    case (a)
      12'hFFF: return 32'hCAFE_F00D;
      12'h011: return 32'hD000_5678;
      12'h008: return 32'h0000_000A;
      12'h009: return 32'h0000_000B;
      12'h00A: return 32'h0000_000C;
      default: return 32'hD000_0000 | {20'h0, a};
    endcase
  endfunction

  task automatic drive_idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_be = 4'hF;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 32'h0; ext_len = 4'h0; ext_wdata = 32'h0;
  endtask

  // Read burst with optional CPU contention from the second cycle on.
  task automatic burst(input logic [31:0] addr, input logic [3:0] len,
                       input int exp_beats, input logic cpu_on);
    logic        prev = 1'b0;
    logic [11:0] base = addr[13:2];
    logic [11:0] pa   = 12'h0;
    for (int c = 0; c < exp_beats + 3; c++) begin
      @(negedge clk);
      ext_req = (c == 0); ext_we = 1'b0; ext_addr = addr; ext_len = len;
      cpu_req = cpu_on && (c > 0); cpu_we = 1'b0; cpu_addr = 32'h0;
      #1;
      chk("burst_rvalid", {31'h0, ext_rvalid}, {31'h0, prev});
      if (prev) chk("burst_rdata", ext_rdata, exp_word(pa));
      chk("burst_gnt", {31'h0, ext_gnt}, {31'h0, (c < exp_beats)});
      if (c < exp_beats) begin
        chk("burst_addr", {20'h0, mem_addr}, {20'h0, base + 12'(c)});
        chk("burst_done", {31'h0, ext_done}, {31'h0, (c == exp_beats - 1)});
        if (cpu_on && c > 0) chk("burst_stall", {31'h0, cpu_stall}, 32'h1);
      end else if (cpu_on) begin
        chk("post_burst_stall", {31'h0, cpu_stall}, 32'h0);
      end
      prev = (c < exp_beats);
      pa   = base + 12'(c);
    end
    drive_idle();
  endtask

  typedef struct {
    logic        cr, cw; logic [31:0] ca, cd; logic [3:0] cb;
    logic        er, ew; logic [31:0] ea; logic [3:0] el; logic [31:0] ed;
    logic        x_en, x_we; logic [11:0] x_addr; logic [3:0] x_be; logic [31:0] x_wd;
    logic        x_stall, x_gnt, x_done;
    logic        x_crv; logic [31:0] x_crd;
    logic        x_erv; logic [31:0] x_erd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // cr cw ca cd cb | er ew ea el ed | en we addr be wd | stall gnt done | crv crd | erv erd
    tbl[0] = '{1'b1,1'b0,32'h10,32'h0,4'hF, 1'b0,1'b0,32'h0,4'h0,32'h0,
               1'b1,1'b0,12'h004,4'hF,32'h0, 1'b0,1'b0,1'b0, 1'b1,32'hD000_0004, 1'b0,32'h0};
    tbl[1] = '{1'b1,1'b1,32'h44,32'h1234_5678,4'h3, 1'b0,1'b0,32'h0,4'h0,32'h0,
               1'b1,1'b1,12'h011,4'h3,32'h1234_5678, 1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0};
    tbl[2] = '{1'b1,1'b0,32'h44,32'h0,4'hF, 1'b0,1'b0,32'h0,4'h0,32'h0,
               1'b1,1'b0,12'h011,4'hF,32'h0, 1'b0,1'b0,1'b0, 1'b1,32'hD000_5678, 1'b0,32'h0};
    tbl[3] = '{1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,4'h0,32'h0,
               1'b0,1'b0,12'h000,4'h0,32'h0, 1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0};
    tbl[4] = '{1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h80,4'h0,32'h0,
               1'b1,1'b0,12'h020,4'hF,32'h0, 1'b0,1'b1,1'b1, 1'b0,32'h0, 1'b1,32'hD000_0020};
    tbl[5] = '{1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b1,32'h3FFC,4'h1,32'hCAFE_F00D,
               1'b1,1'b1,12'hFFF,4'hF,32'hCAFE_F00D, 1'b0,1'b1,1'b1, 1'b0,32'h0, 1'b0,32'h0};
    tbl[6] = '{1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h3FFC,4'h1,32'h0,
               1'b1,1'b0,12'hFFF,4'hF,32'h0, 1'b0,1'b1,1'b1, 1'b0,32'h0, 1'b1,32'hCAFE_F00D};
    tbl[7] = '{1'b1,1'b0,32'h0001_0010,32'h0,4'hF, 1'b0,1'b0,32'h0,4'h0,32'h0,
               1'b1,1'b0,12'h004,4'hF,32'h0, 1'b0,1'b0,1'b0, 1'b1,32'hD000_0004, 1'b0,32'h0};
    tbl[8] = '{1'b1,1'b0,32'h8,32'h0,4'hF, 1'b1,1'b0,32'hC,4'h1,32'h0,
               1'b1,1'b0,12'h002,4'hF,32'h0, 1'b0,1'b0,1'b0, 1'b1,32'hD000_0002, 1'b0,32'h0};
    tbl[9] = '{1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'hC,4'h1,32'h0,
               1'b1,1'b0,12'h003,4'hF,32'h0, 1'b0,1'b1,1'b1, 1'b0,32'h0, 1'b1,32'hD000_0003};

    // Reset state
    rst = 1'b1;
    drive_idle();
    @(negedge clk); #1;
    chk("rst_mem_en",     {31'h0, mem_en},     32'h0);
    chk("rst_ext_gnt",    {31'h0, ext_gnt},    32'h0);
    chk("rst_cpu_rvalid", {31'h0, cpu_rvalid}, 32'h0);
    chk("rst_ext_rvalid", {31'h0, ext_rvalid}, 32'h0);
    chk("rst_cpu_stall",  {31'h0, cpu_stall},  32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle vector table
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      cpu_req = tbl[v].cr; cpu_we = tbl[v].cw; cpu_addr = tbl[v].ca;
      cpu_wdata = tbl[v].cd; cpu_be = tbl[v].cb;
      ext_req = tbl[v].er; ext_we = tbl[v].ew; ext_addr = tbl[v].ea;
      ext_len = tbl[v].el; ext_wdata = tbl[v].ed;
      #1;
      chk($sformatf("v%0d_mem_en", v),    {31'h0, mem_en},    {31'h0, tbl[v].x_en});
      chk($sformatf("v%0d_mem_we", v),    {31'h0, mem_we},    {31'h0, tbl[v].x_we});
      chk($sformatf("v%0d_mem_addr", v),  {20'h0, mem_addr},  {20'h0, tbl[v].x_addr});
      chk($sformatf("v%0d_mem_be", v),    {28'h0, mem_be},    {28'h0, tbl[v].x_be});
      chk($sformatf("v%0d_mem_wdata", v), mem_wdata,          tbl[v].x_wd);
      chk($sformatf("v%0d_cpu_stall", v), {31'h0, cpu_stall}, {31'h0, tbl[v].x_stall});
      chk($sformatf("v%0d_ext_gnt", v),   {31'h0, ext_gnt},   {31'h0, tbl[v].x_gnt});
      chk($sformatf("v%0d_ext_done", v),  {31'h0, ext_done},  {31'h0, tbl[v].x_done});
      @(posedge clk); #1;
      chk($sformatf("v%0d_cpu_rvalid", v), {31'h0, cpu_rvalid}, {31'h0, tbl[v].x_crv});
      chk($sformatf("v%0d_cpu_rdata", v),  cpu_rdata,            tbl[v].x_crd);
      chk($sformatf("v%0d_ext_rvalid", v), {31'h0, ext_rvalid}, {31'h0, tbl[v].x_erv});
      chk($sformatf("v%0d_ext_rdata", v),  ext_rdata,            tbl[v].x_erd);
    end
    @(negedge clk);
    drive_idle();

    // External write burst of three words at word 8
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ext_req = (k == 0); ext_we = 1'b1; ext_addr = 32'h20; ext_len = 4'd3;
      ext_wdata = 32'hA + 32'(k);
      #1;
      chk("wb_gnt",   {31'h0, ext_gnt},  32'h1);
      chk("wb_addr",  {20'h0, mem_addr}, 32'h8 + 32'(k));
      chk("wb_we",    {31'h0, mem_we},   32'h1);
      chk("wb_wdata", mem_wdata,         32'hA + 32'(k));
      chk("wb_done",  {31'h0, ext_done}, {31'h0, (k == 2)});
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk("wb_after_gnt",    {31'h0, ext_gnt}, 32'h0);
    chk("wb_after_mem_en", {31'h0, mem_en},  32'h0);

    // Starvation: CPU served four times, then external wins
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h40; ext_len = 4'd1;
      #1;
      if (i < 5) begin
        chk("starve_cpu_stall", {31'h0, cpu_stall}, 32'h0);
        chk("starve_ext_gnt",   {31'h0, ext_gnt},   32'h0);
        chk("starve_cpu_addr",  {20'h0, mem_addr},  32'h0);
      end else begin
        chk("starve_win_gnt",   {31'h0, ext_gnt},   32'h1);
        chk("starve_win_stall", {31'h0, cpu_stall}, 32'h1);
        chk("starve_win_addr",  {20'h0, mem_addr},  32'h10);
        chk("starve_win_done",  {31'h0, ext_done},  32'h1);
      end
    end
    @(negedge clk);
    ext_req = 1'b0;
    #1;
    chk("starve_after_stall", {31'h0, cpu_stall}, 32'h0);
    chk("starve_ext_rvalid",  {31'h0, ext_rvalid}, 32'h1);
    chk("starve_ext_rdata",   ext_rdata, 32'hD000_0010);
    @(negedge clk);
    ext_req = 1'b1;
    #1;
    chk("starve_cleared_stall", {31'h0, cpu_stall}, 32'h0);
    chk("starve_cleared_gnt",   {31'h0, ext_gnt},   32'h0);
    drive_idle();

    // Burst length clamp, length-0 single beat, and address wrap
    burst(32'h100,  4'd15, 8, 1'b1);
    burst(32'h300,  4'd0,  1, 1'b0);
    burst(32'h3FFC, 4'd3,  3, 1'b0);

    // Reset during the second beat of a four-beat read burst
    @(negedge clk);
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h200; ext_len = 4'd4;
    #1;
    chk("rb_beat0_gnt",  {31'h0, ext_gnt},  32'h1);
    chk("rb_beat0_addr", {20'h0, mem_addr}, 32'h80);
    @(negedge clk);
    ext_req = 1'b0;
    #1;
    chk("rb_beat1_gnt",    {31'h0, ext_gnt},    32'h1);
    chk("rb_beat1_addr",   {20'h0, mem_addr},   32'h81);
    chk("rb_beat1_rvalid", {31'h0, ext_rvalid}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rb_rst_gnt",        {31'h0, ext_gnt},    32'h0);
    chk("rb_rst_mem_en",     {31'h0, mem_en},     32'h0);
    chk("rb_rst_done",       {31'h0, ext_done},   32'h0);
    chk("rb_rst_ext_rvalid", {31'h0, ext_rvalid}, 32'h0);
    chk("rb_rst_ext_rdata",  ext_rdata,           32'h0);
    chk("rb_rst_cpu_stall",  {31'h0, cpu_stall},  32'h0);
    @(negedge clk);
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    #1;
    chk("rb_post_cpu_en",    {31'h0, mem_en},    32'h1);
    chk("rb_post_cpu_addr",  {20'h0, mem_addr},  32'h4);
    chk("rb_post_cpu_stall", {31'h0, cpu_stall}, 32'h0);
    chk("rb_post_gnt",       {31'h0, ext_gnt},   32'h0);
    @(negedge clk);
    drive_idle();
    #1;
    chk("rb_post_cpu_rvalid", {31'h0, cpu_rvalid}, 32'h1);
    chk("rb_post_cpu_rdata",  cpu_rdata, 32'hD000_0004);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("rb_no_done", {31'h0, ext_done}, 32'h0);
      chk("rb_no_gnt",  {31'h0, ext_gnt},  32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
